// File: rtl/uart_msg_ctl.sv
// UART-side message controller: echo / uppercase echo through a FIFO, or
// periodic / triggered sends of a host-written message, over valid/ready.
module uart_msg_ctl #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int MSG_DEPTH  = 32,
    parameter int PERIOD     = 100000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    input  logic                         trig,
    input  logic [DW-1:0]                rx_data,
    input  logic                         rx_valid,
    output logic [DW-1:0]                tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    input  logic                         msg_we,
    input  logic [$clog2(MSG_DEPTH)-1:0] msg_addr,
    input  logic [DW-1:0]                msg_wdata,
    input  logic                         msg_len_we,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         ovf,
    output logic                         busy
);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int MAW = $clog2(MSG_DEPTH);
    localparam int CW  = $clog2(PERIOD);

    typedef enum logic [1:0] {IDLE, ECHO, SEND} state_t;

    state_t          state;
    logic [DW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0]  wr_ptr, rd_ptr;
    logic [DW-1:0]   msg_mem [MSG_DEPTH];
    logic [MAW:0]    len_reg, send_len, last_idx;
    logic [MAW-1:0]  idx;
    logic [CW-1:0]   per_cnt;
    logic            pending, per_mode_q;
    logic            full, push, pop, take, wrap, echo_mode;

    function automatic logic [DW-1:0] upcase(input logic [DW-1:0] b);
        if (b >= DW'(8'h61) && b <= DW'(8'h7A)) return b - DW'(8'h20);
        return b;
    endfunction

    assign echo_mode = (mode == 2'd0) || (mode == 2'd3);
    assign full      = (fifo_count == (FAW+1)'(FIFO_DEPTH));
    // A write colliding with a pop while full is still dropped.
    assign push      = rx_valid && !full;
    assign pop       = (state == IDLE) && echo_mode && (fifo_count != '0);
    assign take      = (state == IDLE) && !echo_mode && pending;
    assign wrap      = (mode == 2'd1) && (per_cnt == CW'(PERIOD - 1));
    assign last_idx  = send_len - 1'b1;
    assign busy      = (state != IDLE);

    // FIFO storage; contents need no reset since occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rx_data;
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ovf        <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (rx_valid && full) ovf <= 1'b1;
        end
    end

    // Host-written message memory (not reset)
    always_ff @(posedge clk) begin
        if (msg_we) msg_mem[msg_addr] <= msg_wdata;
    end

    // Length register; the FSM snapshots it when a send starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             len_reg <= '0;
        else if (msg_len_we) len_reg <= msg_len;
    end

    // Period counter and pending-send flag; a new request never stacks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt    <= '0;
            pending    <= 1'b0;
            per_mode_q <= 1'b0;
        end else begin
            per_mode_q <= (mode == 2'd1);
            if (mode != 2'd1 || wrap) per_cnt <= '0;
            else                      per_cnt <= per_cnt + 1'b1;
            if (per_mode_q && mode != 2'd1)         pending <= 1'b0;
            else if (wrap || (mode == 2'd2 && trig)) pending <= 1'b1;
            else if (take)                           pending <= 1'b0;
        end
    end

    // Main FSM: IDLE between echoed bytes, SEND drops valid between message bytes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            idx      <= '0;
            send_len <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= (mode == 2'd3) ? upcase(fifo_mem[rd_ptr]) : fifo_mem[rd_ptr];
                        tx_valid <= 1'b1;
                        state    <= ECHO;
                    end else if (take && len_reg != '0) begin
                        send_len <= len_reg;
                        idx      <= '0;
                        state    <= SEND;
                    end
                end
                ECHO: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                SEND: begin
                    if (!tx_valid) begin
                        tx_data  <= msg_mem[idx];
                        tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (idx == last_idx[MAW-1:0]) state <= IDLE;
                        else                          idx   <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_msg_ctl.sv
// Scoreboard bench for uart_msg_ctl: stimulus pushes expected tx bytes,
// a negedge monitor pops and compares every transfer and checks stall holding.
module tb_uart_msg_ctl;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       trig;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       msg_we;
    logic [4:0] msg_addr;
    logic [7:0] msg_wdata;
    logic       msg_len_we;
    logic [5:0] msg_len;
    logic [4:0] fifo_count;
    logic       ovf;
    logic       busy;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;

    uart_msg_ctl #(.DW(8), .FIFO_DEPTH(16), .MSG_DEPTH(32), .PERIOD(50)) dut (
        .clk(clk), .rst(rst), .mode(mode), .trig(trig),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .msg_we(msg_we), .msg_addr(msg_addr), .msg_wdata(msg_wdata),
        .msg_len_we(msg_len_we), .msg_len(msg_len),
        .fifo_count(fifo_count), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: transfers happen at the next rising edge when valid & ready now
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                n_chk++;
                if (!(tx_valid === 1'b1 && tx_data === hold_d)) begin
                    n_fail++;
                    $display("FAIL hold: valid=%0b data=%h, required valid=1 data=%h", tx_valid, tx_data, hold_d);
                end
            end
            if (tx_valid && tx_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_unexpected: got %h, required no transfer", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        n_fail++;
                        $display("FAIL tx_byte: got %h, required %h", tx_data, e);
                    end
                end
            end
            hold_v = tx_valid && !tx_ready;
            hold_d = tx_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic send_rx(input logic [7:0] d);
        rx_data = d; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic wr_msg(input logic [4:0] a, input logic [7:0] d);
        msg_addr = a; msg_wdata = d; msg_we = 1'b1;
        tick();
        msg_we = 1'b0;
    endtask

    task automatic set_len(input logic [5:0] l);
        msg_len = l; msg_len_we = 1'b1;
        tick();
        msg_len_we = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int maxc, input string name);
        int i;
        i = 0;
        while (busy !== lvl && i < maxc) begin tick(); i++; end
        chk(name, busy, lvl);
    endtask

    task automatic push_msg(input int n);
        logic [7:0] m [4];
        m[0] = 8'h48; m[1] = 8'h69; m[2] = 8'h0D; m[3] = 8'h0A;
        for (int i = 0; i < n; i++) exp_q.push_back(m[i]);
    endtask

    initial begin
        int t1, t2, nb;
        rst = 1'b1; mode = 2'd0; trig = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        tx_ready = 1'b1; msg_we = 1'b0; msg_addr = '0; msg_wdata = '0;
        msg_len_we = 1'b0; msg_len = '0;
        #3;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        tick(); tick();
        rst = 1'b0;

        wr_msg(5'd0, 8'h48); wr_msg(5'd1, 8'h69); wr_msg(5'd2, 8'h0D); wr_msg(5'd3, 8'h0A);
        set_len(6'd4);
        tick();

        // Echo with latency check: rx in cycle k, tx_valid in cycle k+2
        exp_q.push_back(8'h41); exp_q.push_back(8'h62);
        rx_data = 8'h41; rx_valid = 1'b1;
        tick();
        rx_data = 8'h62;
        chk("echo_lat_k1", tx_valid, 0);
        tick();
        rx_valid = 1'b0;
        chk("echo_lat_k2", tx_valid, 1);
        chk("echo_first_data", tx_data, 8'h41);
        repeat (8) tick();
        chk("echo_fifo_empty", fifo_count, 0);

        // Uppercase echo
        mode = 2'd3;
        exp_q.push_back(8'h41); exp_q.push_back(8'h5A); exp_q.push_back(8'h5B); exp_q.push_back(8'h7B);
        send_rx(8'h61); send_rx(8'h7A); send_rx(8'h5B); send_rx(8'h7B);
        repeat (15) tick();

        // Overflow: one byte parked in tx_data, then 17 more against a 16-entry FIFO
        mode = 2'd0; tx_ready = 1'b0;
        exp_q.push_back(8'h80);
        send_rx(8'h80);
        repeat (3) tick();
        chk("ovf_pre_count", fifo_count, 0);
        chk("ovf_pre_flag", ovf, 0);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'h90 + 8'(i));
            send_rx(8'h90 + 8'(i));
        end
        tick();
        chk("ovf_full_count", fifo_count, 16);
        chk("ovf_flag", ovf, 1);
        chk("ovf_held_valid", tx_valid, 1);
        chk("ovf_held_data", tx_data, 8'h80);
        tx_ready = 1'b1;
        repeat (40) tick();
        chk("ovf_drained", fifo_count, 0);
        chk("ovf_sticky", ovf, 1);

        // Periodic send every 50 cycles
        mode = 2'd1;
        wait_busy(1'b1, 60, "per_start1");
        push_msg(4); t1 = cyc;
        wait_busy(1'b0, 20, "per_end1");
        wait_busy(1'b1, 60, "per_start2");
        push_msg(4); t2 = cyc;
        chk("per_interval", t2 - t1, 50);
        wait_busy(1'b0, 20, "per_end2");
        // Stall the third message for 60 cycles; a wrap lands meanwhile
        wait_busy(1'b1, 60, "per_start3");
        tx_ready = 1'b0;
        push_msg(4);
        repeat (60) tick();
        tx_ready = 1'b1;
        push_msg(4);
        wait_busy(1'b0, 20, "stall_end");
        wait_busy(1'b1, 3, "back_to_back");
        wait_busy(1'b0, 20, "b2b_end");
        nb = 0;
        repeat (15) begin tick(); if (busy) nb++; end
        chk("no_third_msg", nb, 0);
        mode = 2'd0;
        repeat (5) tick();

        // One-shot: two trigs during a send yield exactly one more message
        set_len(6'd3);
        mode = 2'd2;
        push_msg(3);
        pulse_trig();
        wait_busy(1'b1, 5, "shot_start");
        tick();
        push_msg(3);
        pulse_trig();
        tick();
        pulse_trig();
        repeat (30) tick();
        chk("shot_two_msgs", exp_q.size(), 0);
        chk("shot_idle", busy, 0);
        set_len(6'd0);
        pulse_trig();
        nb = 0;
        repeat (10) begin tick(); if (tx_valid) nb++; end
        chk("len0_no_tx", nb, 0);

        // Reset in the middle of a stalled message with bytes in the FIFO
        set_len(6'd4);
        tx_ready = 1'b0;
        send_rx(8'h11); send_rx(8'h22);
        push_msg(4);
        pulse_trig();
        for (int i = 0; i < 10 && !tx_valid; i++) tick();
        chk("rst_pre_valid", tx_valid, 1);
        chk("rst_pre_count", fifo_count, 2);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", tx_valid, 0);
        chk("rst_mid_count", fifo_count, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ovf", ovf, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tx_ready = 1'b1;
        pulse_trig();
        nb = 0;
        repeat (8) begin tick(); if (tx_valid) nb++; end
        chk("len_reset_no_tx", nb, 0);
        mode = 2'd0;
        exp_q.push_back(8'h5A);
        send_rx(8'h5A);
        repeat (8) tick();
        chk("post_rst_drained", fifo_count, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
